// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyser capture controller.
package la_pkg;

   // Capture FSM states; the encoding is visible on the state output.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_READ  = 2'd3
   } la_state_e;

   // Configuration register map.
   localparam logic [1:0] CFG_ADDR_DIV   = 2'd0;
   localparam logic [1:0] CFG_ADDR_MASK  = 2'd1;
   localparam logic [1:0] CFG_ADDR_VALUE = 2'd2;
   localparam logic [1:0] CFG_ADDR_POST  = 2'd3;

   // Default geometry.
   localparam int NUM_CH_DEF = 7;
   localparam int DEPTH_DEF  = 80;
   localparam int DIV_W_DEF  = 8;

   // Widths of the config data bus and the post-trigger count.
   localparam int CFG_W  = 8;
   localparam int POST_W = 8;

   // A post count can never exceed the buffer: the trigger sample itself
   // occupies one slot, so DEPTH-1 is the largest meaningful value.
   function automatic logic [POST_W-1:0] clamp_post(input logic [CFG_W-1:0] data,
                                                     input int depth);
      if (int'(data) >= depth) begin
         return POST_W'(depth - 1);
      end
      return data;
   endfunction

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Control, config and readout signals of the capture controller.
interface la_capture_ctrl_if
   import la_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF
);
   logic              ena;
   logic              cfg_we;
   logic [1:0]        cfg_addr;
   logic [CFG_W-1:0]  cfg_data;
   logic              arm;
   logic              abort;
   logic [NUM_CH-1:0] ch_in;
   logic              rd_ready;
   logic              sample_en;
   logic              rd_valid;
   logic              rd_shift;
   logic [1:0]        state;
   logic              triggered;
   logic              done;

   // Host / test side: drives control, config and live channels.
   modport master (
      output ena, cfg_we, cfg_addr, cfg_data, arm, abort, ch_in, rd_ready,
      input  sample_en, rd_valid, rd_shift, state, triggered, done
   );

   // Controller side.
   modport slave (
      input  ena, cfg_we, cfg_addr, cfg_data, arm, abort, ch_in, rd_ready,
      output sample_en, rd_valid, rd_shift, state, triggered, done
   );
endinterface

// File: rtl/la_sample_divider.sv
// Sample-rate divider: one tick every div+1 enabled cycles.
module la_sample_divider #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] r_cnt;

   // The tick fires on the last enabled cycle of each period.
   assign tick = en && (r_cnt >= div);

   // Count enabled cycles; restart at the period end, hold when disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values and simulation matches hardware.
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_cnt >= div) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: arm, trigger, post-trigger capture
// and buffer readout sequencing.
module la_capture_ctrl
   import la_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int DIV_W  = DIV_W_DEF
) (
   input logic              clk,
   input logic              rst_n,
   la_capture_ctrl_if.slave bus
);
   localparam int              RD_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [RD_W-1:0] RD_LAST = RD_W'(DEPTH - 1);

   la_state_e         r_state;
   logic [DIV_W-1:0]  r_div;
   logic [NUM_CH-1:0] r_trig_mask;
   logic [NUM_CH-1:0] r_trig_value;
   logic [POST_W-1:0] r_post;
   logic [POST_W-1:0] r_post_cnt;
   logic [RD_W-1:0]   r_rd_cnt;
   logic              r_triggered;
   logic              r_done;

   logic w_capture;
   logic w_div_en;
   logic w_div_clear;
   logic w_tick;
   logic w_trig_hit;
   logic w_rd_valid;
   logic w_rd_shift;

   assign w_capture   = (r_state == ST_ARMED) || (r_state == ST_POST);
   assign w_div_en    = bus.ena & w_capture;
   // Holding the divider clear outside capture guarantees it starts from
   // zero on entry to ARMED; abort clears it immediately.
   assign w_div_clear = bus.abort | ~w_capture;
   assign w_trig_hit  = ((bus.ch_in ^ r_trig_value) & r_trig_mask) == '0;
   assign w_rd_valid  = (r_state == ST_READ);
   assign w_rd_shift  = w_rd_valid & bus.rd_ready & bus.ena;

   la_sample_divider #(
      .DIV_W (DIV_W)
   ) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (w_div_clear),
      .en    (w_div_en),
      .div   (r_div),
      .tick  (w_tick)
   );

   // Config registers accept writes only while idle so a capture in
   // flight always runs with a consistent setup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div        <= '0;
         r_trig_mask  <= '0;
         r_trig_value <= '0;
         r_post       <= '0;
      end else if (bus.cfg_we && (r_state == ST_IDLE)) begin
         case (bus.cfg_addr)
            CFG_ADDR_DIV:   r_div        <= DIV_W'(bus.cfg_data);
            CFG_ADDR_MASK:  r_trig_mask  <= NUM_CH'(bus.cfg_data);
            CFG_ADDR_VALUE: r_trig_value <= NUM_CH'(bus.cfg_data);
            default:        r_post       <= clamp_post(bus.cfg_data, DEPTH);
         endcase
      end
   end

   // Capture FSM with its counters and registered flags; abort overrides
   // every other event and never produces a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_post_cnt  <= '0;
         r_rd_cnt    <= '0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.abort) begin
            r_state     <= ST_IDLE;
            r_post_cnt  <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.arm) begin
                     r_state     <= ST_ARMED;
                     r_triggered <= 1'b0;
                  end
               end
               ST_ARMED: begin
                  // The trigger sample is itself captured; post more follow.
                  if (w_tick && w_trig_hit) begin
                     r_triggered <= 1'b1;
                     if (r_post == '0) begin
                        r_state <= ST_READ;
                     end else begin
                        r_state    <= ST_POST;
                        r_post_cnt <= r_post - 1'b1;
                     end
                  end
               end
               ST_POST: begin
                  if (w_tick) begin
                     if (r_post_cnt == '0) begin
                        r_state <= ST_READ;
                     end else begin
                        r_post_cnt <= r_post_cnt - 1'b1;
                     end
                  end
               end
               default: begin
                  // ST_READ: drain the whole buffer, one handshake per entry.
                  if (w_rd_shift) begin
                     if (r_rd_cnt == RD_LAST) begin
                        r_state  <= ST_IDLE;
                        r_rd_cnt <= '0;
                        r_done   <= 1'b1;
                     end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.sample_en = w_tick & w_capture;
   assign bus.rd_valid  = w_rd_valid;
   assign bus.rd_shift  = w_rd_shift;
   assign bus.state     = r_state;
   assign bus.triggered = r_triggered;
   assign bus.done      = r_done;
endmodule

// File: doc/la_capture_ctrl.md
LA_CAPTURE_CTRL -- requirements
Module: la_capture_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 7: number of sampled channels.
REQ-002 SHALL have parameter DEPTH, default 80: samples held per channel buffer.
REQ-003 SHALL have parameter DIV_W, default 8: sample-rate divider width.
REQ-004 SHALL provide ports:
- clk  in  1  sole clock; rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  2  config address.
- cfg_data  in  8  config write data.
- arm  in  1  start-capture pulse.
- abort  in  1  cancel pulse.
- ch_in  in  NUM_CH  live channel inputs, for the trigger.
- rd_ready  in  1  readout consumer ready.
- sample_en  out  1  buffer shift-in enable.
- rd_valid  out  1  readout data valid.
- rd_shift  out  1  buffer shift-out strobe.
- state  out  2  FSM state: IDLE=0, ARMED=1, POST=2, READ=3.
- triggered  out  1  trigger seen flag.
- done  out  1  capture-complete pulse.

Function
REQ-005 SHALL hold config registers: addr 0 div[DIV_W-1:0], addr 1 trig_mask[NUM_CH-1:0], addr 2 trig_value[NUM_CH-1:0], addr 3 post[7:0].
- post values of DEPTH or more are clamped to DEPTH-1 on write.
REQ-006 SHALL accept cfg writes only in IDLE; writes in other states are ignored.
REQ-007 SHALL generate a sample tick once every div+1 enabled cycles in ARMED/POST.
- Divider counter is cleared on entry to ARMED and runs only when ena=1.
REQ-008 SHALL drive sample_en combinationally = tick AND state in {ARMED, POST}.
REQ-009 SHALL define the trigger condition as ((ch_in XOR trig_value) AND trig_mask) == 0, evaluated only on ticks in ARMED.
- trig_mask=0 therefore triggers on the first tick.
REQ-010 SHALL use these FSM transitions:
- IDLE -> ARMED on arm.
- ARMED -> POST on a trigger tick with post>0.
- ARMED -> READ on a trigger tick with post=0.
- POST -> READ on the tick where post_cnt=0.
- READ -> IDLE after DEPTH handshakes.
REQ-011 SHALL include the trigger sample itself in the capture, then capture exactly post further samples.
- post_cnt is loaded with post-1 on the trigger tick and decremented on each POST tick.
REQ-012 SHALL assert rd_valid throughout READ.
- rd_shift = rd_valid AND rd_ready.
- An internal counter counts rd_shift pulses from 0 to DEPTH-1.
REQ-013 SHALL pulse done for exactly one cycle, in the cycle after the DEPTH-th rd_shift, coincident with state=IDLE.
REQ-014 SHALL set triggered on the trigger tick and clear it on arm or abort.
REQ-015 SHALL give abort priority over every other event: next state IDLE, all counters cleared, sample_en/rd_valid low from the next cycle, no done pulse.
REQ-016 SHALL ignore arm outside IDLE; arm and abort in the same cycle results in IDLE.
REQ-017 SHALL, with ena=0, freeze the divider and all counters and hold sample_en=0 and rd_shift=0, while still honouring abort and reset.
REQ-018 SHALL wrap no counter; every counter is bounded by its terminal condition.

Reset
REQ-019 SHALL on rst_n=0, asynchronously:
- state=IDLE.
- div, trig_mask, trig_value, post = 0.
- All counters = 0.
- sample_en, rd_valid, rd_shift, triggered, done = 0.
REQ-020 SHALL treat reset mid-capture or mid-readout identically to power-on; no partial done.

Structure
REQ-021 SHALL place in shared package la_pkg: state enum, cfg address constants, default NUM_CH and DEPTH.
REQ-022 SHALL implement the divider as sub-module la_sample_divider (inputs clk, rst_n, clear, en, div; output tick).

Verification
REQ-023 Reset with arm held high -> all outputs 0 and state=IDLE until rst_n rises; no transition until the next arm pulse.
REQ-024 div=3, mask=0, post=5, arm -> sample_en on cycles 4, 8, ..., 24 (6 pulses); then READ.
- 80 handshakes with rd_ready=1 -> done pulses once; state=IDLE.
REQ-025 mask=0x01, value=0x01, div=0, post=0; ch_in[0] rises 10 cycles after arm -> triggered set that cycle; next state READ.
REQ-026 READ with rd_ready toggled 1/0 -> rd_shift only when ready=1; exactly 80 rd_shift pulses before done.
REQ-027 abort asserted in POST after 2 of 5 post samples -> IDLE next cycle, triggered=0, no done.
- A cfg write of div=7 in ARMED is ignored; the same write in IDLE takes effect.
REQ-028 ena=0 for 20 cycles during ARMED with div=1 -> no sample_en; tick spacing resumes from the frozen count.
